// File: rtl/pwm_multi_if.sv
// Register-side bundle for pwm_multi: configuration/control inputs and PWM status outputs.
// The master drives configuration; the slave (the PWM block) drives the outputs.
interface pwm_multi_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  logic                      enable;
  logic                      load;
  logic                      mode_in;
  logic [WIDTH-1:0]          top_in;
  logic [CHANNELS*WIDTH-1:0] duty_in;
  logic [CHANNELS-1:0]       polarity;

  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_start;
  logic [WIDTH-1:0]          cnt_out;
  logic                      pending;

  modport master (
    output enable, load, mode_in, top_in, duty_in, polarity,
    input  pwm_out, period_start, cnt_out, pending
  );

  modport slave (
    input  enable, load, mode_in, top_in, duty_in, polarity,
    output pwm_out, period_start, cnt_out, pending
  );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared fast/phase-correct timebase, per-channel compare outputs,
// and a shadow register set that is promoted to the active set only at a period boundary.
module pwm_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic         clk,
  input  logic         reset,
  pwm_multi_if.slave   bus
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  typedef struct packed {
    logic                      mode;
    logic [WIDTH-1:0]          top;
    logic [CHANNELS*WIDTH-1:0] duty;
  } cfg_t;

  cfg_t                shadow_q, shadow_d;
  cfg_t                active_q, active_d;
  logic                pending_q, pending_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  dir_e                dir_q, dir_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_start_q, period_start_d;

  logic [WIDTH-1:0]    cnt_step;
  dir_e                dir_step;
  logic                wrap;
  logic                apply_ok;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q       <= '0;
      active_q       <= '0;
      pending_q      <= 1'b0;
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

  // Candidate timebase step when running; a zero result marks the period boundary.
  // NOTE: every variable written in a comb block gets a default first, so no latch is inferred.
  always_comb begin
    cnt_step = '0;
    dir_step = DIR_UP;
    if (!active_q.mode) begin
      cnt_step = (cnt_q >= active_q.top) ? '0 : cnt_q + 1'b1;
    end else if (active_q.top == '0) begin
      cnt_step = '0;
    end else if ((dir_q == DIR_UP || cnt_q == '0) && cnt_q < active_q.top) begin
      cnt_step = cnt_q + 1'b1;
    end else begin
      cnt_step = cnt_q - 1'b1;
      dir_step = (cnt_q == WIDTH'(1)) ? DIR_UP : DIR_DOWN;
    end
  end

  assign wrap     = bus.enable && (cnt_step == '0);
  // While idle the shadow is applied immediately; while running only at a wrap.
  assign apply_ok = bus.enable ? wrap : 1'b1;

  // Next-state logic.
  always_comb begin
    shadow_d       = shadow_q;
    active_d       = active_q;
    pending_d      = pending_q;
    cnt_d          = '0;
    dir_d          = DIR_UP;
    period_start_d = 1'b0;

    if (bus.enable) begin
      cnt_d          = cnt_step;
      dir_d          = wrap ? DIR_UP : dir_step;
      period_start_d = wrap;
    end

    // A load colliding with the boundary wins: it refreshes the shadow and defers the apply.
    if (bus.load) begin
      shadow_d.mode = bus.mode_in;
      shadow_d.top  = bus.top_in;
      shadow_d.duty = bus.duty_in;
      pending_d     = 1'b1;
    end else if (pending_q && apply_ok) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Output logic: per-channel compare against the current count, polarity applied live.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.enable)
        pwm_d[i] = (cnt_q < active_q.duty[i*WIDTH +: WIDTH]) ^ bus.polarity[i];
      else
        pwm_d[i] = bus.polarity[i];
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = period_start_q;
  assign bus.cnt_out      = cnt_q;
  assign bus.pending      = pending_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: a period-position model checked every cycle, plus
// literal expectations for counts, sequences and shadow-register timing.
module tb_pwm_multi;
  localparam int W = 16;
  localparam int C = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pwm_multi_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  pwm_multi #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the period; counter value derived from it arithmetically.
  int             m_pos = 0;
  bit             m_mode = 0;
  int             m_top = 0;
  int             m_duty [C] = '{default: 0};
  bit             s_mode = 0;
  int             s_top = 0;
  int             s_duty [C] = '{default: 0};
  bit             m_pend = 0;
  logic [C-1:0]   m_pwm = '0;
  bit             m_ps = 0;
  int             m_c;
  bit             m_wrap;
  bit             m_apply;

  function automatic int period_len();
    if (!m_mode) return m_top + 1;
    return (m_top == 0) ? 1 : 2 * m_top;
  endfunction

  function automatic int cnt_at(input int pos);
    if (!m_mode || pos <= m_top) return pos;
    return 2 * m_top - pos;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_pos = 0; m_mode = 0; m_top = 0; s_mode = 0; s_top = 0;
      m_pend = 0; m_pwm = '0; m_ps = 0;
      for (int i = 0; i < C; i++) begin m_duty[i] = 0; s_duty[i] = 0; end
    end else begin
      if (bus.enable) begin
        m_c = cnt_at(m_pos);
        for (int i = 0; i < C; i++) m_pwm[i] = (m_c < m_duty[i]) ^ bus.polarity[i];
        m_wrap  = (m_pos >= period_len() - 1);
        m_pos   = m_wrap ? 0 : m_pos + 1;
        m_ps    = m_wrap;
        m_apply = m_wrap;
      end else begin
        m_pos = 0; m_pwm = bus.polarity; m_ps = 0; m_apply = 1;
      end
      if (bus.load) begin
        s_mode = bus.mode_in;
        s_top  = int'(bus.top_in);
        for (int i = 0; i < C; i++) s_duty[i] = int'(bus.duty_in[i*W +: W]);
        m_pend = 1;
      end else if (m_pend && m_apply) begin
        m_mode = s_mode; m_top = s_top;
        for (int i = 0; i < C; i++) m_duty[i] = s_duty[i];
        m_pend = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("cmp_cnt_out",      bus.cnt_out,      cnt_at(m_pos));
    check("cmp_pwm_out",      bus.pwm_out,      m_pwm);
    check("cmp_period_start", bus.period_start, m_ps);
    check("cmp_pending",      bus.pending,      m_pend);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input bit mode, input int top, input int d0, input int d1,
                         input int d2, input int d3);
    bus.load    = 1'b1;
    bus.mode_in = mode;
    bus.top_in  = W'(top);
    bus.duty_in = {W'(d3), W'(d2), W'(d1), W'(d0)};
    tick();
    bus.load    = 1'b0;
  endtask

  task automatic wait_cnt(input string name, input int value);
    int n = 0;
    while (int'(bus.cnt_out) != value && n < 200) begin tick(); n++; end
    if (n >= 200) check(name, 0, 1);
  endtask

  task automatic wait_applied(input string name);
    int n = 0;
    while (bus.pending !== 1'b0 && n < 200) begin tick(); n++; end
    if (n >= 200) check(name, 0, 1);
  endtask

  task automatic wait_ps(input string name);
    int n = 0;
    while (bus.period_start !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) check(name, 0, 1);
  endtask

  int hi [C];
  int ps_cnt;

  task automatic count_window(input int cycles);
    ps_cnt = 0;
    for (int i = 0; i < C; i++) hi[i] = 0;
    for (int k = 0; k < cycles; k++) begin
      for (int i = 0; i < C; i++) hi[i] += int'(bus.pwm_out[i]);
      ps_cnt += int'(bus.period_start);
      tick();
    end
  endtask

  int tri_seq [9] = '{0, 1, 2, 3, 4, 3, 2, 1, 0};

  initial begin
    bus.enable = 1'b0; bus.load = 1'b0; bus.mode_in = 1'b0;
    bus.top_in = '0; bus.duty_in = '0; bus.polarity = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("reset_pwm", bus.pwm_out, 0);
    check("reset_cnt", bus.cnt_out, 0);
    check("reset_pending", bus.pending, 0);

    bus.polarity = 4'b0101;
    tick();
    check("idle_polarity", bus.pwm_out, 4'b0101);
    bus.polarity = 4'b0000;

    // Fast mode, top 9, duties 0/3/10/12.
    do_load(0, 9, 0, 3, 10, 12);
    check("load_pending", bus.pending, 1);
    tick();
    check("idle_apply", bus.pending, 0);
    bus.enable = 1'b1;
    tick();
    check("enable_cnt1", bus.cnt_out, 1);
    check("first_pwm", bus.pwm_out, 4'b1110);
    wait_ps("to_fast_ps");
    count_window(20);
    check("fast_ps_count", ps_cnt, 2);
    check("fast_hi0", hi[0], 0);
    check("fast_hi1", hi[1], 6);
    check("fast_hi2", hi[2], 20);
    check("fast_hi3", hi[3], 20);

    // Shadow: load at cnt 3 applies only at the next wrap.
    wait_cnt("to_cnt3", 3);
    do_load(0, 9, 5, 3, 10, 12);
    check("shadow_pending", bus.pending, 1);
    wait_cnt("to_cnt9", 9);
    check("shadow_hold", bus.pending, 1);
    tick();
    check("shadow_wrap_cnt", bus.cnt_out, 0);
    check("shadow_applied", bus.pending, 0);
    count_window(10);
    check("shadow_hi0", hi[0], 5);

    // Load on the wrap cycle is deferred one full period.
    wait_cnt("to_wrap_cycle", 9);
    do_load(0, 9, 7, 3, 10, 12);
    check("defer_ps", bus.period_start, 1);
    check("defer_pending", bus.pending, 1);
    repeat (9) tick();
    check("defer_hold", bus.pending, 1);
    tick();
    check("defer_applied", bus.pending, 0);
    count_window(10);
    check("defer_hi0", hi[0], 7);

    // Fast -> phase-correct with top 1.
    do_load(1, 1, 1, 1, 1, 1);
    wait_applied("to_phase1");
    for (int k = 0; k < 4; k++) begin
      check("phase1_cnt", bus.cnt_out, k % 2);
      check("phase1_ps", bus.period_start, (k % 2 == 0) ? 1 : 0);
      tick();
    end

    // top 0: wrap every cycle.
    do_load(1, 0, 0, 0, 0, 0);
    wait_applied("to_top0");
    for (int k = 0; k < 3; k++) begin
      check("top0_ps", bus.period_start, 1);
      check("top0_cnt", bus.cnt_out, 0);
      tick();
    end

    // Phase-correct top 4, duty 2 (ch3 duty 5).
    do_load(1, 4, 2, 2, 2, 5);
    wait_applied("to_phase4");
    for (int k = 0; k < 9; k++) begin
      check("tri_seq", bus.cnt_out, tri_seq[k]);
      if (k < 8) tick();
    end
    count_window(8);
    check("tri_ps_count", ps_cnt, 1);
    check("tri_hi0", hi[0], 3);
    check("tri_hi3", hi[3], 8);

    // Reset mid-period with a pending shadow.
    bus.polarity = 4'b0101;
    do_load(0, 9, 1, 1, 1, 1);
    check("pre_reset_pending", bus.pending, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_pwm", bus.pwm_out, 0);
    check("rst_mid_cnt", bus.cnt_out, 0);
    check("rst_mid_ps", bus.period_start, 0);
    check("rst_mid_pending", bus.pending, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("post_rst_pending", bus.pending, 0);
    check("post_rst_cnt", bus.cnt_out, 0);
    check("post_rst_ps", bus.period_start, 1);
    check("post_rst_pwm", bus.pwm_out, 4'b0101);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
